// File: rtl/data_memory_pkg.sv
// Shared encodings and helpers for the RV64 data memory and its load path.
package data_memory_pkg;

  localparam int BE_W = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Byte mask for an access of the given size code, anchored at lane 0.
  function automatic logic [BE_W-1:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0f;
      default: size_mask = 8'hff;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_load_extend.sv
// Selects the sized field at a byte offset of a doubleword and sign/zero extends it.
module load_extend
  import data_memory_pkg::*;
(
  input  logic [63:0] word,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] result
);

  logic [63:0] shifted;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    case (funct3)
      F3_B:    result = {{56{shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    result = {{32{shifted[31]}}, shifted[31:0]};
      F3_D:    result = shifted;
      F3_BU:   result = {56'd0, shifted[7:0]};
      F3_HU:   result = {48'd0, shifted[15:0]};
      F3_WU:   result = {32'd0, shifted[31:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable 64-bit data memory with sized loads, lane stores and a sticky fault record.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [63:0] Address,
  input  logic [63:0] WriteData,
  input  logic        FaultClear,
  output logic [63:0] ReadData,
  output logic        Misaligned,
  output logic        FaultSticky,
  output logic [63:0] FaultAddr
);

  localparam int IDXW = $clog2(DEPTH);

  logic [63:0]     mem [DEPTH];
  logic [IDXW-1:0] idx;
  logic [2:0]      offset;
  logic            active;
  logic            out_of_range;
  logic            misalign;
  logic            illegal;
  logic            fault;
  logic [BE_W-1:0] be;
  logic [63:0]     wdata;
  logic [63:0]     ext;

  assign idx    = Address[IDXW+2:3];
  assign offset = Address[2:0];
  assign active = MemRead | MemWrite;

  always_comb begin
    out_of_range = |Address[63:IDXW+3];
    case (Funct3[1:0])
      2'b01:   misalign = Address[0];
      2'b10:   misalign = |Address[1:0];
      2'b11:   misalign = |Address[2:0];
      default: misalign = 1'b0;
    endcase
    illegal = (Funct3 == 3'b111) | (MemWrite & Funct3[2]);
    fault   = active & (out_of_range | misalign | illegal);
  end

  assign Misaligned = fault;

  load_extend u_load_extend (
    .word   (mem[idx]),
    .offset (offset),
    .funct3 (Funct3),
    .result (ext)
  );

  assign ReadData = (MemRead && !fault) ? ext : '0;

  assign be    = size_mask(Funct3[1:0]) << offset;
  assign wdata = WriteData << {offset, 3'b000};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (MemWrite && !fault) begin
      for (int b = 0; b < BE_W; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // A new fault outranks a clear; an already-held fault is never overwritten otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      FaultSticky <= 1'b0;
      FaultAddr   <= '0;
    end else if (fault && (!FaultSticky || FaultClear)) begin
      FaultSticky <= 1'b1;
      FaultAddr   <= Address;
    end else if (FaultClear) begin
      FaultSticky <= 1'b0;
      FaultAddr   <= '0;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Random and directed checks of data_memory against a byte-array reference model.
module tb_data_memory;

  localparam int DEPTH = 64;
  localparam int NBYTES = DEPTH * 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, FaultClear;
  logic [2:0]  Funct3;
  logic [63:0] Address, WriteData;
  logic [63:0] ReadData;
  logic        Misaligned;
  logic        FaultSticky;
  logic [63:0] FaultAddr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  m_mem [NBYTES];
  logic        m_sticky;
  logic [63:0] m_faddr;

  logic [63:0] o_rd, o_fa;
  logic        o_mis, o_st;

  always #5 clk = ~clk;

  data_memory #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Funct3      (Funct3),
    .Address     (Address),
    .WriteData   (WriteData),
    .FaultClear  (FaultClear),
    .ReadData    (ReadData),
    .Misaligned  (Misaligned),
    .FaultSticky (FaultSticky),
    .FaultAddr   (FaultAddr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic model_fault(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [63:0] a);
    logic oor, mis, ill;
    if (!(rd || wr)) return 1'b0;
    oor = (a >= 64'(NBYTES));
    mis = (f3 != 3'd7) && ((a % 64'(acc_size(f3))) != 0);
    ill = (f3 == 3'd7) || (wr && f3 >= 3'd4);
    return oor || mis || ill;
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] a);
    logic [63:0] v;
    int sz;
    sz = acc_size(f3);
    v = 0;
    for (int i = 0; i < sz; i++) v |= 64'(m_mem[int'(a) + i]) << (8 * i);
    if (sz < 8 && f3 < 3'd4 && v[8*sz-1]) v |= ~((64'd1 << (8 * sz)) - 1);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NBYTES; i++) m_mem[i] = 8'h00;
    m_sticky = 1'b0;
    m_faddr  = 64'd0;
  endtask

  // One access cycle; starts and ends on a falling edge.
  task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                    input logic [63:0] a, input logic [63:0] wd, input logic clr);
    logic f;
    logic [63:0] exp_rd;
    MemRead = rd; MemWrite = wr; Funct3 = f3; Address = a; WriteData = wd; FaultClear = clr;
    #1;
    f = model_fault(rd, wr, f3, a);
    exp_rd = (rd && !f) ? model_load(f3, a) : 64'd0;
    o_rd = ReadData;
    o_mis = Misaligned;
    check("readdata", ReadData, exp_rd);
    check("misaligned", 64'(Misaligned), 64'(f));
    @(posedge clk);
    if (wr && !f)
      for (int i = 0; i < acc_size(f3); i++) m_mem[int'(a) + i] = wd[8*i +: 8];
    if (f && (!m_sticky || clr)) begin
      m_sticky = 1'b1; m_faddr = a;
    end else if (clr) begin
      m_sticky = 1'b0; m_faddr = 64'd0;
    end
    #1;
    o_st = FaultSticky;
    o_fa = FaultAddr;
    check("sticky", 64'(FaultSticky), 64'(m_sticky));
    check("faultaddr", FaultAddr, m_faddr);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    MemRead = 0; MemWrite = 0; FaultClear = 0; Funct3 = 0; Address = 0; WriteData = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    op(1, 0, 3'b011, 64'h10, 0, 0);
    check("reset_rd", o_rd, 64'd0);
    check("reset_st", 64'(o_st), 64'd0);

    op(0, 1, 3'b000, 64'h9, 64'h80, 0);
    op(1, 0, 3'b000, 64'h9, 0, 0);
    check("lb_sext", o_rd, 64'hFFFFFFFFFFFFFF80);
    op(1, 0, 3'b100, 64'h9, 0, 0);
    check("lbu_zext", o_rd, 64'h80);
    op(1, 0, 3'b011, 64'h8, 0, 0);
    check("ld_byte", o_rd, 64'h8000);

    op(0, 1, 3'b011, 64'h0, 64'h1122334455667788, 0);
    op(0, 1, 3'b001, 64'h2, 64'hBEEF, 0);
    op(1, 0, 3'b011, 64'h0, 0, 0);
    check("lane_ld", o_rd, 64'h11223344BEEF7788);
    op(1, 0, 3'b010, 64'h4, 0, 0);
    check("lane_lw", o_rd, 64'h11223344);

    op(0, 1, 3'b010, 64'h6, 64'hDEADBEEF, 0);
    check("sw_mis", 64'(o_mis), 64'd1);
    check("sw_mis_st", 64'(o_st), 64'd1);
    check("sw_mis_fa", o_fa, 64'h6);
    op(1, 0, 3'b011, 64'h0, 0, 0);
    check("mis_nowrite", o_rd, 64'h11223344BEEF7788);
    op(1, 0, 3'b001, 64'h3, 0, 0);
    check("fa_hold", o_fa, 64'h6);

    op(0, 0, 3'b000, 64'h0, 0, 1);
    check("clr_st", 64'(o_st), 64'd0);
    check("clr_fa", o_fa, 64'd0);
    op(1, 0, 3'b011, 64'(NBYTES), 0, 1);
    check("clr_vs_fault_rd", o_rd, 64'd0);
    check("clr_vs_fault_st", 64'(o_st), 64'd1);
    check("clr_vs_fault_fa", o_fa, 64'(NBYTES));

    op(1, 1, 3'b011, 64'h18, 64'hA5A5A5A5A5A5A5A5, 0);
    check("rbw_old", o_rd, 64'd0);
    op(1, 0, 3'b011, 64'h18, 0, 0);
    check("rbw_new", o_rd, 64'hA5A5A5A5A5A5A5A5);

    MemRead = 1; MemWrite = 1; Funct3 = 3'b011; Address = 64'h18;
    WriteData = 64'h0123456789ABCDEF; FaultClear = 0;
    @(posedge clk); #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_rd", ReadData, 64'd0);
    check("async_st", 64'(FaultSticky), 64'd0);
    check("async_fa", FaultAddr, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    op(1, 0, 3'b011, 64'h18, 0, 0);
    check("lost_store", o_rd, 64'd0);

    for (int n = 0; n < 600; n++) begin
      logic [63:0] a, wd;
      logic [2:0] f3;
      logic rd, wr, clr;
      if ($urandom_range(0, 7) == 0) a = {$urandom, $urandom};
      else a = 64'($urandom_range(0, NBYTES - 1));
      if ($urandom_range(0, 3) != 0) a = a & ~64'(acc_size(3'($urandom_range(0, 3))) - 1);
      f3 = 3'($urandom_range(0, 7));
      wd = {$urandom, $urandom};
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 15) == 0);
      op(rd, wr, f3, a, wd, clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
